// File: rtl/conv_sequencer_pkg.sv
// Shared definitions for the convolution sequencer: FSM state encoding,
// SRAM port indices used by the SRAM controller, and small helpers.
package conv_sequencer_pkg;

  // Sequencer FSM states
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    RUN      = 3'd2,
    DRAIN    = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } seq_state_e;

  // SRAM controller port indices (image operand, kernel operand, results)
  localparam int unsigned SRAM_GEMM0 = 0;
  localparam int unsigned SRAM_GEMM1 = 1;
  localparam int unsigned SRAM_ELEM  = 2;

  // Saturating 32-bit increment for the performance counters
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/conv_tap_delay.sv
// Aligns the issue-cycle tap strobe, tap index and last-tap flag with SRAM
// read data by delaying them LAT cycles. LAT=0 is a plain pass-through.
module conv_tap_delay #(
  parameter int LAT   = 1,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_last,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
    logic             last;
  } tap_t;

  generate
    if (LAT == 0) begin : g_bypass
      assign out_valid = in_valid;
      assign out_idx   = in_idx;
      assign out_last  = in_last;
    end else begin : g_pipe
      tap_t pipe_q [LAT];
      tap_t pipe_d [LAT];

      // Next value of each stage: stage 0 takes the issue-cycle tap, the rest shift
      always_comb begin
        pipe_d[0] = '{vld: in_valid, idx: in_idx, last: in_last};
        for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];
      end

      // Shift register with synchronous clear
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
        end else begin
          for (int i = 0; i < LAT; i++) pipe_q[i] <= pipe_d[i];
        end
      end

      assign out_valid = pipe_q[LAT-1].vld;
      assign out_idx   = pipe_q[LAT-1].idx;
      assign out_last  = pipe_q[LAT-1].last;
    end
  endgenerate

endmodule

// File: rtl/conv_sequencer.sv
// Convolution control sequencer. Latches image/kernel dimensions on start,
// validates them, walks the sliding window issuing one image-tap and one
// kernel-tap read per unstalled cycle, counts MAC results into the ELEM
// write port and pulses done.
// Optional: define CONV_SEQ_PERF_EN to add stall/run cycle counters.
module conv_sequencer
  import conv_sequencer_pkg::*;
#(
  parameter int ADDR_WIDTH  = 13,
  parameter int MAX_MACS    = 64,
  parameter int SRAM_RD_LAT = 1
) (
  input  logic                           s00_axis_aclk,
  input  logic                           s00_axis_aresetn,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          img_row,
  input  logic [ADDR_WIDTH-1:0]          img_col,
  input  logic [ADDR_WIDTH-1:0]          ker_row,
  input  logic [ADDR_WIDTH-1:0]          ker_col,
  input  logic                           stall,
  input  logic                           mac_valid_out,
  output logic                           img_rd_en,
  output logic [ADDR_WIDTH-1:0]          img_rd_addr,
  output logic                           ker_rd_en,
  output logic [ADDR_WIDTH-1:0]          ker_rd_addr,
  output logic                           tap_valid,
  output logic [$clog2(MAX_MACS)-1:0]    tap_idx,
  output logic                           window_last,
  output logic [$clog2(MAX_MACS+1)-1:0]  num_macs,
  output logic                           res_wr_en,
  output logic [ADDR_WIDTH-1:0]          res_wr_addr,
  output logic [ADDR_WIDTH-1:0]          out_size,
`ifdef CONV_SEQ_PERF_EN
  output logic [31:0]                    perf_stall_cycles,
  output logic [31:0]                    perf_run_cycles,
`endif
  output logic                           busy,
  output logic                           done,
  output logic                           cfg_err
);

  localparam int AW    = ADDR_WIDTH;
  localparam int IDX_W = $clog2(MAX_MACS);
  localparam int NM_W  = $clog2(MAX_MACS+1);
  localparam int DR_W  = (SRAM_RD_LAT > 0) ? $clog2(SRAM_RD_LAT+1) : 1;
  localparam logic [2*AW-1:0] MAX_MACS_W = (2*AW)'(MAX_MACS);

  seq_state_e        state_q, state_d;
  logic [AW-1:0]     img_row_q, img_row_d, img_col_q, img_col_d;
  logic [AW-1:0]     ker_row_q, ker_row_d, ker_col_q, ker_col_d;
  logic [AW-1:0]     out_row_q, out_row_d, out_col_q, out_col_d;
  logic [AW-1:0]     conv_row_q, conv_row_d, conv_col_q, conv_col_d;
  logic [AW-1:0]     kr_q, kr_d, kc_q, kc_d;
  logic [IDX_W-1:0]  tap_q, tap_d;
  logic [AW-1:0]     res_cnt_q, res_cnt_d;
  logic [AW-1:0]     out_size_q, out_size_d;
  logic [NM_W-1:0]   num_macs_q, num_macs_d;
  logic [DR_W-1:0]   drain_q, drain_d;
  logic              busy_q, busy_d, done_q, done_d, cfg_err_q, cfg_err_d;

  // Dimension checks, evaluated on the latched values during CHECK
  logic [AW-1:0]     out_row_c, out_col_c;
  logic [2*AW-1:0]   ker_prod, out_prod;
  logic              cfg_bad;

  assign out_row_c = img_row_q - ker_row_q + AW'(1);
  assign out_col_c = img_col_q - ker_col_q + AW'(1);
  assign ker_prod  = (2*AW)'(ker_row_q) * (2*AW)'(ker_col_q);
  assign out_prod  = (2*AW)'(out_row_c) * (2*AW)'(out_col_c);
  assign cfg_bad   = (ker_row_q == '0) || (ker_col_q == '0) ||
                     (ker_row_q > img_row_q) || (ker_col_q > img_col_q) ||
                     (ker_prod > MAX_MACS_W) || (out_prod[2*AW-1:AW] != '0);

  // Window walk control
  logic          issue, last_tap, last_col, last_row, res_accept;
  logic [AW-1:0] img_addr;

  assign issue    = (state_q == RUN) && !stall;
  assign last_tap = (kc_q == ker_col_q - AW'(1)) && (kr_q == ker_row_q - AW'(1));
  assign last_col = (conv_col_q == out_col_q - AW'(1));
  assign last_row = (conv_row_q == out_row_q - AW'(1));
  // Computed at ADDR_WIDTH so the address wraps exactly like the SRAM port
  assign img_addr = (conv_row_q + kr_q) * img_col_q + conv_col_q + kc_q;

  // Results past out_size are dropped; nothing is counted outside the run
  assign res_accept = mac_valid_out &&
                      (state_q inside {RUN, DRAIN, WAIT_RES}) &&
                      (res_cnt_q < out_size_q);

  // Next-state, counter and status computation
  always_comb begin
    state_d    = state_q;
    img_row_d  = img_row_q;
    img_col_d  = img_col_q;
    ker_row_d  = ker_row_q;
    ker_col_d  = ker_col_q;
    out_row_d  = out_row_q;
    out_col_d  = out_col_q;
    conv_row_d = conv_row_q;
    conv_col_d = conv_col_q;
    kr_d       = kr_q;
    kc_d       = kc_q;
    tap_d      = tap_q;
    res_cnt_d  = res_cnt_q;
    out_size_d = out_size_q;
    num_macs_d = num_macs_q;
    drain_d    = drain_q;

    if (res_accept) res_cnt_d = res_cnt_q + AW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          img_row_d = img_row;
          img_col_d = img_col;
          ker_row_d = ker_row;
          ker_col_d = ker_col;
          res_cnt_d = '0;
          state_d   = CHECK;
        end
      end
      CHECK: begin
        if (cfg_bad) begin
          state_d = IDLE;
        end else begin
          out_row_d  = out_row_c;
          out_col_d  = out_col_c;
          out_size_d = out_prod[AW-1:0];
          num_macs_d = ker_prod[NM_W-1:0];
          conv_row_d = '0;
          conv_col_d = '0;
          kr_d       = '0;
          kc_d       = '0;
          tap_d      = '0;
          res_cnt_d  = '0;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (issue) begin
          if (last_tap) begin
            kc_d  = '0;
            kr_d  = '0;
            tap_d = '0;
            if (last_col) begin
              conv_col_d = '0;
              if (last_row) begin
                conv_row_d = '0;
                drain_d    = '0;
                state_d    = (SRAM_RD_LAT == 0) ? WAIT_RES : DRAIN;
              end else begin
                conv_row_d = conv_row_q + AW'(1);
              end
            end else begin
              conv_col_d = conv_col_q + AW'(1);
            end
          end else begin
            tap_d = tap_q + IDX_W'(1);
            if (kc_q == ker_col_q - AW'(1)) begin
              kc_d = '0;
              kr_d = kr_q + AW'(1);
            end else begin
              kc_d = kc_q + AW'(1);
            end
          end
        end
      end
      DRAIN: begin
        // Let the reads still in the SRAM pipe emerge before waiting on results
        if (drain_q == DR_W'(SRAM_RD_LAT - 1)) state_d = WAIT_RES;
        else                                   drain_d = drain_q + DR_W'(1);
      end
      WAIT_RES: begin
        if ((res_cnt_q == out_size_q) ||
            (res_accept && (res_cnt_q + AW'(1) == out_size_q)))
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    cfg_err_d = (state_q == CHECK) && cfg_bad;
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q    <= IDLE;
      img_row_q  <= '0;
      img_col_q  <= '0;
      ker_row_q  <= '0;
      ker_col_q  <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      conv_row_q <= '0;
      conv_col_q <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      tap_q      <= '0;
      res_cnt_q  <= '0;
      out_size_q <= '0;
      num_macs_q <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_row_q  <= img_row_d;
      img_col_q  <= img_col_d;
      ker_row_q  <= ker_row_d;
      ker_col_q  <= ker_col_d;
      out_row_q  <= out_row_d;
      out_col_q  <= out_col_d;
      conv_row_q <= conv_row_d;
      conv_col_q <= conv_col_d;
      kr_q       <= kr_d;
      kc_q       <= kc_d;
      tap_q      <= tap_d;
      res_cnt_q  <= res_cnt_d;
      out_size_q <= out_size_d;
      num_macs_q <= num_macs_d;
      drain_q    <= drain_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Tap strobes follow the read data out of the SRAM
  conv_tap_delay #(
    .LAT   (SRAM_RD_LAT),
    .IDX_W (IDX_W)
  ) u_tap_delay (
    .clk       (s00_axis_aclk),
    .rst_n     (s00_axis_aresetn),
    .in_valid  (issue),
    .in_idx    (issue ? tap_q : '0),
    .in_last   (issue && last_tap),
    .out_valid (tap_valid),
    .out_idx   (tap_idx),
    .out_last  (window_last)
  );

  // Read ports: addresses stay on the held tap while stalled, zero outside RUN
  assign img_rd_en   = issue;
  assign ker_rd_en   = issue;
  assign img_rd_addr = (state_q == RUN) ? img_addr : '0;
  assign ker_rd_addr = (state_q == RUN) ? AW'(tap_q) : '0;

  assign res_wr_en   = res_accept;
  assign res_wr_addr = res_cnt_q;
  assign out_size    = out_size_q;
  assign num_macs    = num_macs_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cfg_err     = cfg_err_q;

`ifdef CONV_SEQ_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d, perf_run_q, perf_run_d;

  // Stall and active-cycle counters, cleared on an accepted start
  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_run_d   = perf_run_q;
    if (state_q == IDLE && start) begin
      perf_stall_d = '0;
      perf_run_d   = '0;
    end else begin
      if (state_q == RUN && stall) perf_stall_d = sat_inc32(perf_stall_q);
      if (state_q inside {RUN, DRAIN, WAIT_RES}) perf_run_d = sat_inc32(perf_run_q);
    end
  end

  // Performance counter registers
  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      perf_stall_q <= '0;
      perf_run_q   <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_run_q   <= perf_run_d;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_run_cycles   = perf_run_q;
`endif

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer.
module tb_conv_sequencer;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0, stall = 1'b0, mac = 1'b0;
  logic [AW-1:0] img_row = '0, img_col = '0, ker_row = '0, ker_col = '0;
  logic          img_rd_en, ker_rd_en, tap_valid, window_last, res_wr_en;
  logic [AW-1:0] img_rd_addr, ker_rd_addr, res_wr_addr, out_size;
  logic [5:0]    tap_idx;
  logic [6:0]    num_macs;
  logic          busy, done, cfg_err;
`ifdef CONV_SEQ_PERF_EN
  logic [31:0]   perf_stall_cycles, perf_run_cycles;
`endif

  conv_sequencer #(.ADDR_WIDTH(AW), .MAX_MACS(64), .SRAM_RD_LAT(1)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rstn),
    .start            (start),
    .img_row          (img_row),
    .img_col          (img_col),
    .ker_row          (ker_row),
    .ker_col          (ker_col),
    .stall            (stall),
    .mac_valid_out    (mac),
    .img_rd_en        (img_rd_en),
    .img_rd_addr      (img_rd_addr),
    .ker_rd_en        (ker_rd_en),
    .ker_rd_addr      (ker_rd_addr),
    .tap_valid        (tap_valid),
    .tap_idx          (tap_idx),
    .window_last      (window_last),
    .num_macs         (num_macs),
    .res_wr_en        (res_wr_en),
    .res_wr_addr      (res_wr_addr),
    .out_size         (out_size),
`ifdef CONV_SEQ_PERF_EN
    .perf_stall_cycles(perf_stall_cycles),
    .perf_run_cycles  (perf_run_cycles),
`endif
    .busy             (busy),
    .done             (done),
    .cfg_err          (cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  // Observations from the most recent run_conv
  int n_issue, n_tapv, n_done, n_err, done_cyc, first_mac_cyc, busy_after, stall_addr, timed_out;
  int img_a[$], ker_a[$], tidx[$], lastp[$], wr_a[$];

  // Reference image address of the n-th issued tap (division form)
  function automatic int exp_img(input int ic, input int kr, input int kc, input int n);
    int win, t, oc;
    win = n / (kr*kc);
    t   = n % (kr*kc);
    oc  = ic - kc + 1;
    return ((win / oc) + (t / kc)) * ic + (win % oc) + (t % kc);
  endfunction

  // Start one convolution and record everything the DUT does until done/cfg_err
  task automatic run_conv(input int ir, input int ic, input int kr, input int kc,
                          input int stall_at, input int stall_len, input int restart_at,
                          input int n_mac, input int total_taps);
    int post, stall_rem, mac_sent;
    bit restarted;
    n_issue = 0; n_tapv = 0; n_done = 0; n_err = 0;
    done_cyc = -1; first_mac_cyc = -1; busy_after = -1; stall_addr = -1; timed_out = 1;
    img_a.delete(); ker_a.delete(); tidx.delete(); lastp.delete(); wr_a.delete();
    post = 0; stall_rem = stall_len; mac_sent = 0; restarted = 0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 0) begin
        img_row = AW'(ir); img_col = AW'(ic); ker_row = AW'(kr); ker_col = AW'(kc);
        start = 1'b1;
      end else if (!restarted && restart_at >= 0 && n_issue == restart_at) begin
        start = 1'b1; restarted = 1;
      end
      stall = (stall_rem > 0) && (n_issue == stall_at);
      if (stall) stall_rem--;
      mac = (total_taps > 0) && (n_tapv == total_taps) && (mac_sent < n_mac);
      if (mac) begin
        mac_sent++;
        if (first_mac_cyc < 0) first_mac_cyc = c;
      end
      #1;
      if (img_rd_en) begin
        n_issue++;
        img_a.push_back(int'(img_rd_addr));
        ker_a.push_back(int'(ker_rd_addr));
      end
      if (stall) stall_addr = int'(img_rd_addr);
      if (tap_valid) begin
        if (window_last) lastp.push_back(n_tapv);
        tidx.push_back(int'(tap_idx));
        n_tapv++;
      end
      if (res_wr_en) wr_a.push_back(int'(res_wr_addr));
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = int'(busy);
      if (cfg_err) n_err++;
      if (n_done > 0 || n_err > 0) post++;
      if (post == 4) begin timed_out = 0; break; end
    end
    @(negedge clk);
    start = 1'b0; stall = 1'b0; mac = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({img_rd_en, img_rd_addr, ker_rd_en, ker_rd_addr, tap_valid, tap_idx, window_last,
         num_macs, res_wr_en, res_wr_addr, out_size, busy, done, cfg_err} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got busy=%0b done=%0b out_size=%0d img_rd_en=%0b exp all zero",
               busy, done, out_size, img_rd_en);
    end
    rstn = 1'b1;
  endtask

  task automatic test_basic_4x4();
    int w0[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int bad;
    run_conv(4, 4, 3, 3, -1, 0, -1, 6, 36);
    checks++; if (timed_out !== 0) begin failures++; $display("FAIL basic_timeout got=%0d exp=0", timed_out); end
    checks++; if (out_size !== 13'd4) begin failures++; $display("FAIL basic_out_size got=%0d exp=4", out_size); end
    checks++; if (num_macs !== 7'd9) begin failures++; $display("FAIL basic_num_macs got=%0d exp=9", num_macs); end
    checks++; if (n_issue != 36) begin failures++; $display("FAIL basic_rd_count got=%0d exp=36", n_issue); end
    checks++; if (n_tapv != 36) begin failures++; $display("FAIL basic_tap_count got=%0d exp=36", n_tapv); end
    bad = 0;
    for (int i = 0; i < 9; i++) if (i >= img_a.size() || img_a[i] != w0[i]) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_win0_addrs got=%0d wrong exp=0", bad); end
    checks++; if (img_a.size() < 10 || img_a[9] != 1) begin failures++;
      $display("FAIL basic_win1_first got=%0d exp=1", (img_a.size() > 9) ? img_a[9] : -1); end
    bad = 0;
    for (int i = 0; i < img_a.size(); i++) if (img_a[i] != exp_img(4, 3, 3, i)) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_img_seq got=%0d wrong exp=0", bad); end
    bad = 0;
    for (int i = 0; i < ker_a.size(); i++) if (ker_a[i] != i % 9) bad++;
    for (int i = 0; i < tidx.size(); i++) if (tidx[i] != i % 9) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_ker_tap_seq got=%0d wrong exp=0", bad); end
    checks++; if (lastp.size() != 4 || lastp[0] != 8 || lastp[1] != 17 || lastp[2] != 26 || lastp[3] != 35) begin
      failures++; $display("FAIL basic_window_last got=%0d marks exp=4 at 8,17,26,35", lastp.size()); end
    bad = (wr_a.size() != 4) ? 1 : 0;
    for (int i = 0; i < wr_a.size(); i++) if (wr_a[i] != i) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL basic_res_addrs got=%0d writes exp=4 (0..3)", wr_a.size()); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
    checks++; if (busy_after !== 0) begin failures++; $display("FAIL basic_busy_after_done got=%0d exp=0", busy_after); end
    checks++; if (res_wr_addr !== 13'd4) begin failures++; $display("FAIL basic_res_addr_hold got=%0d exp=4", res_wr_addr); end
  endtask

  task automatic test_cfg_err();
    run_conv(9, 9, 9, 9, -1, 0, -1, 0, 0);
    checks++; if (n_err != 1 || n_issue != 0 || n_done != 0) begin failures++;
      $display("FAIL cfg_err_81taps got err=%0d rd=%0d done=%0d exp 1/0/0", n_err, n_issue, n_done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL cfg_err_idle got busy=%0b exp=0", busy); end
    run_conv(4, 4, 5, 5, -1, 0, -1, 0, 0);
    checks++; if (n_err != 1 || n_issue != 0 || n_done != 0) begin failures++;
      $display("FAIL cfg_err_ker_gt_img got err=%0d rd=%0d done=%0d exp 1/0/0", n_err, n_issue, n_done); end
    run_conv(4, 4, 0, 3, -1, 0, -1, 0, 0);
    checks++; if (n_err != 1 || n_issue != 0) begin failures++;
      $display("FAIL cfg_err_zero_ker got err=%0d rd=%0d exp 1/0", n_err, n_issue); end
  endtask

  task automatic test_stall();
    int bad;
    run_conv(4, 4, 3, 3, 20, 3, -1, 4, 36);
    checks++; if (n_issue != 36 || n_tapv != 36) begin failures++;
      $display("FAIL stall_counts got rd=%0d tap=%0d exp=36/36", n_issue, n_tapv); end
    checks++; if (stall_addr != 6) begin failures++; $display("FAIL stall_held_addr got=%0d exp=6", stall_addr); end
    bad = 0;
    for (int i = 0; i < img_a.size(); i++) if (img_a[i] != exp_img(4, 3, 3, i)) bad++;
    for (int i = 0; i < tidx.size(); i++) if (tidx[i] != i % 9) bad++;
    checks++; if (bad != 0) begin failures++; $display("FAIL stall_seq got=%0d wrong exp=0", bad); end
    checks++; if (n_done != 1 || timed_out != 0) begin failures++; $display("FAIL stall_done got=%0d exp=1", n_done); end
`ifdef CONV_SEQ_PERF_EN
    checks++; if (perf_stall_cycles !== 32'd3) begin failures++;
      $display("FAIL stall_perf got=%0d exp=3", perf_stall_cycles); end
`endif
  endtask

  task automatic test_start_during_run();
    int bad;
    run_conv(4, 4, 3, 3, -1, 0, 5, 4, 36);
    bad = 0;
    for (int i = 0; i < img_a.size(); i++) if (img_a[i] != exp_img(4, 3, 3, i)) bad++;
    checks++; if (n_issue != 36 || bad != 0 || n_done != 1 || n_err != 0) begin failures++;
      $display("FAIL restart_ignored got rd=%0d bad=%0d done=%0d exp 36/0/1", n_issue, bad, n_done); end
  endtask

  task automatic test_reset_mid_run();
    int dn;
    @(negedge clk);
    img_row = 13'd4; img_col = 13'd4; ker_row = 13'd3; ker_col = 13'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    checks++; if (img_rd_en !== 1'b1) begin failures++; $display("FAIL midrun_active got=%0b exp=1", img_rd_en); end
    rstn = 1'b0;
    @(negedge clk); #1;
    checks++;
    if ({img_rd_en, img_rd_addr, ker_rd_en, ker_rd_addr, tap_valid, tap_idx, window_last,
         num_macs, res_wr_en, res_wr_addr, out_size, busy, done, cfg_err} !== '0) begin
      failures++;
      $display("FAIL midrun_reset_outputs got busy=%0b tap_valid=%0b img_rd_en=%0b exp all zero",
               busy, tap_valid, img_rd_en);
    end
    rstn = 1'b1;
    dn = 0;
    repeat (10) begin @(negedge clk); #1; if (done) dn++; end
    checks++; if (dn != 0) begin failures++; $display("FAIL midrun_no_done got=%0d exp=0", dn); end
    run_conv(4, 4, 3, 3, -1, 0, -1, 4, 36);
    checks++; if (n_issue != 36 || n_done != 1 || wr_a.size() != 4) begin failures++;
      $display("FAIL post_reset_run got rd=%0d done=%0d wr=%0d exp 36/1/4", n_issue, n_done, wr_a.size()); end
  endtask

  task automatic test_single_window();
    run_conv(3, 3, 3, 3, -1, 0, -1, 1, 9);
    checks++; if (out_size !== 13'd1) begin failures++; $display("FAIL single_out_size got=%0d exp=1", out_size); end
    checks++; if (n_issue != 9 || lastp.size() != 1) begin failures++;
      $display("FAIL single_taps got rd=%0d last=%0d exp 9/1", n_issue, lastp.size()); end
    checks++; if (n_done != 1 || done_cyc - first_mac_cyc != 1) begin failures++;
      $display("FAIL single_done_latency got=%0d exp=1", done_cyc - first_mac_cyc); end
    checks++; if (wr_a.size() != 1 || wr_a[0] != 0) begin failures++;
      $display("FAIL single_res got=%0d writes exp=1 at 0", wr_a.size()); end
  endtask

  initial begin
    test_reset();
    test_basic_4x4();
    test_cfg_err();
    test_stall();
    test_start_during_run();
    test_reset_mid_run();
    test_single_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
